mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 25 ++
 rtl/sat_cnt16.sv | 20 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the I/D memory arbiter: default widths,
// FSM state encoding and the round-robin pick helper.
package mem_pkg;

   localparam int ADDR_W_DEF = 28;
   localparam int DATA_W_DEF = 128;
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   // D wins when it is the only requester, or when both request and I was served last.
   function automatic logic pick_d(input logic req_i, input logic req_d, input port_t last);
      return req_d && (!req_i || (last == PORT_I));
   endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
import mem_pkg::*;

module sat_cnt16 (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on inc, hold at the maximum value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single slow memory.
// Round-robin grant evaluated only in IDLE, one mandatory IDLE bubble
// after every completion, and three saturating statistics counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate unless this is the bubble cycle
// SERVE_I | I-cache request latched and driven to memory, wait ready
// SERVE_D | D-cache request latched and driven to memory, wait ready
import mem_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              mem_read_I,
   input  logic              mem_write_I,
   input  logic [ADDR_W-1:0] mem_addr_I,
   input  logic [DATA_W-1:0] mem_wdata_I,
   output logic [DATA_W-1:0] mem_rdata_I,
   output logic              mem_ready_I,

   input  logic              mem_read_D,
   input  logic              mem_write_D,
   input  logic [ADDR_W-1:0] mem_addr_D,
   input  logic [DATA_W-1:0] mem_wdata_D,
   output logic [DATA_W-1:0] mem_rdata_D,
   output logic              mem_ready_D,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,

   output logic [15:0]       cnt_I,
   output logic [15:0]       cnt_D,
   output logic [15:0]       stall_cyc
);

   arb_state_t state, state_nxt;
   port_t      last;
   logic       bubble;

   logic       req_i, req_d;
   logic       grant_i, grant_d;
   logic       done;
   logic       stall_i, stall_d;

   assign req_i = mem_read_I | mem_write_I;
   assign req_d = mem_read_D | mem_write_D;

   // Ready is only forwarded to the port currently being served.
   assign mem_ready_I = (state == SERVE_I) & mem_ready;
   assign mem_ready_D = (state == SERVE_D) & mem_ready;

   assign mem_rdata_I = mem_rdata;
   assign mem_rdata_D = mem_rdata;

   // Next-state decode: grant from IDLE (skipped in the bubble), finish on ready.
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (!bubble) begin
               if (pick_d(req_i, req_d, last)) begin
                  grant_d   = 1'b1;
                  state_nxt = SERVE_D;
               end else if (req_i) begin
                  grant_i   = 1'b1;
                  state_nxt = SERVE_I;
               end
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_ready) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, round-robin history, bubble flag and the latched memory request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= PORT_I;
         bubble    <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state  <= state_nxt;
         bubble <= done;
         if (done) begin
            last      <= (state == SERVE_D) ? PORT_D : PORT_I;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end else if (grant_d) begin
            mem_addr  <= mem_addr_D;
            mem_wdata <= mem_wdata_D;
            mem_write <= mem_write_D;
            mem_read  <= mem_read_D & ~mem_write_D;
         end else if (grant_i) begin
            mem_addr  <= mem_addr_I;
            mem_wdata <= mem_wdata_I;
            mem_write <= mem_write_I;
            mem_read  <= mem_read_I & ~mem_write_I;
         end
      end
   end

   // A port stalls while it asks for memory but is not the one being served.
   assign stall_i = req_i & (state != SERVE_I) & ~mem_ready_I;
   assign stall_d = req_d & (state != SERVE_D) & ~mem_ready_D;

   sat_cnt16 u_cnt_i (
      .clk   (clk),
      .rst   (rst),
      .inc   (done & (state == SERVE_I)),
      .count (cnt_I)
   );

   sat_cnt16 u_cnt_d (
      .clk   (clk),
      .rst   (rst),
      .inc   (done & (state == SERVE_D)),
      .count (cnt_D)
   );

   sat_cnt16 u_cnt_stall (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_i | stall_d),
      .count (stall_cyc)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a slow-memory model that raises
// ready four cycles after a strobe appears.
module tb_mem_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst;

   logic          mem_read_I, mem_write_I;
   logic [AW-1:0] mem_addr_I;
   logic [DW-1:0] mem_wdata_I, mem_rdata_I;
   logic          mem_ready_I;

   logic          mem_read_D, mem_write_D;
   logic [AW-1:0] mem_addr_D;
   logic [DW-1:0] mem_wdata_D, mem_rdata_D;
   logic          mem_ready_D;

   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ready;

   logic [15:0]   cnt_I, cnt_D, stall_cyc;

   logic          mdl_ready;
   logic [2:0]    mdl_cnt;
   logic          force_ready;
   logic          hold_ready;

   int            vectors     = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_read_I  (mem_read_I),
      .mem_write_I (mem_write_I),
      .mem_addr_I  (mem_addr_I),
      .mem_wdata_I (mem_wdata_I),
      .mem_rdata_I (mem_rdata_I),
      .mem_ready_I (mem_ready_I),
      .mem_read_D  (mem_read_D),
      .mem_write_D (mem_write_D),
      .mem_addr_D  (mem_addr_D),
      .mem_wdata_D (mem_wdata_D),
      .mem_rdata_D (mem_rdata_D),
      .mem_ready_D (mem_ready_D),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .cnt_I       (cnt_I),
      .cnt_D       (cnt_D),
      .stall_cyc   (stall_cyc)
   );

   // Slow memory: strobe seen on 4 consecutive edges -> one-cycle ready.
   assign mem_ready = mdl_ready | force_ready;
   assign mem_rdata = {4{4'hC, mem_addr}};

   always @(posedge clk) begin
      if (rst || !(mem_read || mem_write) || mdl_ready) begin
         mdl_ready <= 1'b0;
         mdl_cnt   <= 3'd0;
      end else if (mdl_cnt == 3'd3) begin
         if (!hold_ready) mdl_ready <= 1'b1;
      end else begin
         mdl_cnt <= mdl_cnt + 3'd1;
      end
   end

   function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
      return {4{4'hC, a}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for the served port's ready; memory address must stay put meanwhile.
   task automatic serve(input bit port_d, input logic [AW-1:0] exp_addr, input string tag);
      int n = 0;
      bit seen = 1'b0;
      bit addr_moved = 1'b0;
      int other_rdy = 0;
      while (!seen && n < 20) begin
         step();
         n++;
         if (mem_addr !== exp_addr) addr_moved = 1'b1;
         if ((port_d ? mem_ready_I : mem_ready_D) !== 1'b0) other_rdy++;
         if ((port_d ? mem_ready_D : mem_ready_I) === 1'b1) seen = 1'b1;
      end
      chk({tag, "_ready_seen"}, seen, 1'b1);
      chk({tag, "_addr_held"}, addr_moved, 1'b0);
      chk({tag, "_other_ready"}, other_rdy, 0);
      chk({tag, "_rdata"}, port_d ? mem_rdata_D : mem_rdata_I, line_of(exp_addr));
      chk({tag, "_rdata_bcast"}, mem_rdata_I, mem_rdata_D);
      step();
      chk({tag, "_ready_single"}, port_d ? mem_ready_D : mem_ready_I, 1'b0);
      chk({tag, "_strobes_idle"}, {mem_read, mem_write}, 2'b00);
      if (port_d) begin
         mem_read_D  = 1'b0;
         mem_write_D = 1'b0;
      end else begin
         mem_read_I  = 1'b0;
         mem_write_I = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            n;
      int            g;
      logic          prev;
      logic [AW-1:0] gaddr [6];

      mem_read_I = 0; mem_write_I = 0; mem_addr_I = '0; mem_wdata_I = '0;
      mem_read_D = 0; mem_write_D = 0; mem_addr_D = '0; mem_wdata_D = '0;
      force_ready = 0; hold_ready = 0;
      do_reset();

      // Reset state
      chk("rst_strobes", {mem_read, mem_write}, 2'b00);
      chk("rst_addr", mem_addr, '0);
      chk("rst_wdata", mem_wdata, '0);
      chk("rst_counters", {cnt_I, cnt_D, stall_cyc}, '0);
      chk("rst_readies", {mem_ready_I, mem_ready_D}, 2'b00);

      // Single I read
      mem_read_I = 1; mem_addr_I = 28'h0000010;
      step();
      chk("t1_grant", {mem_read, mem_write}, 2'b10);
      chk("t1_addr", mem_addr, 28'h0000010);
      serve(1'b0, 28'h0000010, "t1");
      chk("t1_cnt_I", cnt_I, 16'd1);
      chk("t1_cnt_D", cnt_D, 16'd0);
      chk("t1_stall", stall_cyc, 16'd1);
      step(); step();

      // Simultaneous I read / D write from reset: D first, I after the bubble
      do_reset();
      mem_read_I = 1; mem_addr_I = 28'h10;
      mem_write_D = 1; mem_addr_D = 28'h20; mem_wdata_D = {4{32'hDEAD_BEEF}};
      step();
      chk("t2_grant_d", {mem_read, mem_write}, 2'b01);
      chk("t2_addr_d", mem_addr, 28'h20);
      chk("t2_wdata_d", mem_wdata, {4{32'hDEAD_BEEF}});
      serve(1'b1, 28'h20, "t2d");
      step();
      chk("t2_bubble", mem_read, 1'b0);
      step();
      chk("t2_grant_i", mem_read, 1'b1);
      chk("t2_addr_i", mem_addr, 28'h10);
      serve(1'b0, 28'h10, "t2i");
      chk("t2_stall", stall_cyc, 16'd8);
      chk("t2_cnt_I", cnt_I, 16'd1);
      chk("t2_cnt_D", cnt_D, 16'd1);
      step(); step();

      // Continuous requests on both ports: grants alternate D, I, ...
      do_reset();
      mem_read_I = 1; mem_addr_I = 28'h40;
      mem_read_D = 1; mem_addr_D = 28'h50;
      g = 0; n = 0; prev = mem_read;
      while ((int'(cnt_I) + int'(cnt_D)) < 6 && n < 300) begin
         step();
         n++;
         if (mem_read && !prev && g < 6) begin
            gaddr[g] = mem_addr;
            g++;
         end
         prev = mem_read;
      end
      mem_read_I = 0; mem_read_D = 0;
      chk("t3_finished", n < 300, 1'b1);
      chk("t3_grants", g, 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("t3_grant%0d", i), gaddr[i], (i % 2 == 0) ? 28'h50 : 28'h40);
      chk("t3_cnt_I", cnt_I, 16'd3);
      chk("t3_cnt_D", cnt_D, 16'd3);
      step(); step();

      // D write whose address changes while being served
      mem_write_D = 1; mem_addr_D = 28'h30; mem_wdata_D = {16{8'hA5}};
      step();
      chk("t4_grant", {mem_read, mem_write}, 2'b01);
      chk("t4_addr", mem_addr, 28'h30);
      mem_addr_D = 28'h99; mem_wdata_D = '0;
      mem_read_I = 1; mem_addr_I = 28'h77;
      serve(1'b1, 28'h30, "t4");
      mem_read_I = 0;
      chk("t4_wdata", mem_wdata, {16{8'hA5}});
      chk("t4_cnt_D", cnt_D, 16'd4);
      step(); step();

      // Reset two cycles into a D read
      mem_read_D = 1; mem_addr_D = 28'h60;
      step();
      chk("t5_grant", mem_read, 1'b1);
      step(); step();
      chk("t5_no_ready", mem_ready_D, 1'b0);
      rst = 1;
      step();
      chk("t5_strobes", {mem_read, mem_write}, 2'b00);
      chk("t5_ready", {mem_ready_I, mem_ready_D}, 2'b00);
      chk("t5_counters", {cnt_I, cnt_D, stall_cyc}, '0);
      rst = 0;
      step();
      chk("t5_regrant", mem_read, 1'b1);
      chk("t5_regrant_addr", mem_addr, 28'h60);
      serve(1'b1, 28'h60, "t5");
      chk("t5_cnt_D", cnt_D, 16'd1);
      step(); step();

      // Stray ready in IDLE
      force_ready = 1;
      #1;
      chk("t6_ready_now", {mem_ready_I, mem_ready_D}, 2'b00);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("t6_ready%0d", i), {mem_ready_I, mem_ready_D, mem_read}, 3'b000);
      end
      force_ready = 0;
      chk("t6_counters", {cnt_I, cnt_D, stall_cyc}, {16'd0, 16'd1, 16'd1});

      // I asserts read and write together: write wins
      mem_read_I = 1; mem_write_I = 1; mem_addr_I = 28'h70; mem_wdata_I = 128'h1234;
      step();
      chk("t7_strobes", {mem_read, mem_write}, 2'b01);
      chk("t7_wdata", mem_wdata, 128'h1234);
      serve(1'b0, 28'h70, "t7");
      chk("t7_cnt_I", cnt_I, 16'd1);
      step(); step();

      // Stall counter saturation: D held in service, I waits
      do_reset();
      hold_ready = 1;
      mem_read_D = 1; mem_addr_D = 28'h80;
      mem_read_I = 1; mem_addr_I = 28'h90;
      for (int i = 0; i < 65600; i++) step();
      chk("t8_stall_sat", stall_cyc, 16'hFFFF);
      chk("t8_still_d", mem_addr, 28'h80);
      hold_ready = 0;
      serve(1'b1, 28'h80, "t8");
      mem_read_I = 0;
      chk("t8_stall_hold", stall_cyc, 16'hFFFF);
      chk("t8_cnt_D", cnt_D, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
